// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiply-accumulate, one Booth digit per clock behind a start/done handshake.
// Optional early termination when the remaining multiplier digits are all zero: define MUL_EARLY_TERM_EN.
module mul_booth_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_Start,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_Signed,
   input  logic                 in_Accumulate,
   input  logic [2*WIDTH-1:0]   in_AccValue,
   output logic                 out_Busy,
   output logic                 out_Done,
   output logic [2*WIDTH-1:0]   out_MulResult
);

   localparam int unsigned D  = WIDTH/2 + 1;
   localparam int unsigned PW = 2*WIDTH + 2;
   localparam int unsigned BW = WIDTH + 3;
   localparam int unsigned RW = 2*WIDTH;
   localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   a_q, a_d;
   logic [PW-1:0]   prod_q, prod_d;
   logic [BW-1:0]   b_q, b_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   result_q, result_d;
   logic            busy_q, done_q;
   logic [PW-1:0]   term;
   logic [PW-1:0]   sum;
   logic            last;
   logic            ext_a, ext_b, ext_c;

   assign ext_a = in_Signed & in_a[WIDTH-1];
   assign ext_b = in_Signed & in_b[WIDTH-1];
   assign ext_c = in_Signed & in_AccValue[RW-1];

   // b_q[2:0] always holds the current Booth triple; the multiplier shifts right two per digit
   always_comb begin
      term = '0;
      case (b_q[2:0])
         3'b001, 3'b010: term = a_q;
         3'b011:         term = {a_q[PW-2:0], 1'b0};
         3'b100:         term = PW'(0) - {a_q[PW-2:0], 1'b0};
         3'b101, 3'b110: term = PW'(0) - a_q;
         default:        term = '0;
      endcase
   end

   assign sum = prod_q + term;

`ifdef MUL_EARLY_TERM_EN
   // all remaining multiplier bits equal: every later digit is zero
   assign last = (cnt_q == CW'(D-1)) || (&b_q[BW-1:2]) || (~|b_q[BW-1:2]);
`else
   assign last = (cnt_q == CW'(D-1));
`endif

   // next-state and datapath update
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         S_RUN: begin
            prod_d = sum;
            a_d    = {a_q[PW-3:0], 2'b00};
            b_d    = {{2{b_q[BW-1]}}, b_q[BW-1:2]};
            cnt_d  = cnt_q + CW'(1);
            if (last) begin
               state_d  = S_DONE;
               result_d = sum[RW-1:0];
            end
         end
         default: begin
            if (in_Start) begin
               state_d = S_RUN;
               a_d     = {{(WIDTH+2){ext_a}}, in_a};
               b_d     = {{2{ext_b}}, in_b, 1'b0};
               prod_d  = in_Accumulate ? {{2{ext_c}}, in_AccValue} : '0;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= (state_d == S_RUN);
         done_q   <= (state_d == S_DONE);
      end
   end

   assign out_Busy      = busy_q;
   assign out_Done      = done_q;
   assign out_MulResult = result_q;

endmodule

// File: tb/tb_mul_booth_iter.sv
// Self-checking bench for mul_booth_iter (WIDTH=32): directed table, control sequences, random ops vs arithmetic model.
module tb_mul_booth_iter;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_Start;
   logic [31:0] in_a, in_b;
   logic        in_Signed, in_Accumulate;
   logic [63:0] in_AccValue;
   logic        out_Busy, out_Done;
   logic [63:0] out_MulResult;

   int n_checks = 0;
   int n_fail   = 0;

   mul_booth_iter #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .in_Start(in_Start), .in_a(in_a), .in_b(in_b),
      .in_Signed(in_Signed), .in_Accumulate(in_Accumulate), .in_AccValue(in_AccValue),
      .out_Busy(out_Busy), .out_Done(out_Done), .out_MulResult(out_MulResult)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic        ac;
      logic [63:0] acc;
      logic [63:0] exp;
   } vec_t;

   // product plus accumulate, modulo 2^64
   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic ac, input logic [63:0] acc);
      logic [63:0] xa, xb;
      xa = {{32{s & a[31]}}, a};
      xb = {{32{s & b[31]}}, b};
      return xa * xb + (ac ? acc : 64'd0);
   endfunction

   // edges from acceptance until Done is visible
   function automatic int exp_lat(input logic [31:0] b, input logic s);
`ifdef MUL_EARLY_TERM_EN
      logic signed [63:0] bv, t;
      bv = {{32{s & b[31]}}, b};
      for (int i = 0; i < 17; i++) begin
         t = bv >>> (2*i + 1);
         if (t == 64'sd0 || t == -64'sd1) return i + 1;
      end
      return 17;
`else
      return (b === 32'hx) ? 0 : 17 + 0 * int'(s);
`endif
   endfunction

   task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // drive a request now, hold it across one rising edge
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic ac, input logic [63:0] acc);
      in_a = a; in_b = b; in_Signed = s; in_Accumulate = ac; in_AccValue = acc;
      in_Start = 1'b1;
      @(posedge clock); #1;
      in_Start = 1'b0;
      in_a = $urandom; in_b = $urandom; in_AccValue = {$urandom, $urandom};
      chk_int("busy_after_accept", int'(out_Busy), 1);
   endtask

   task automatic wait_done(input string name, output logic [63:0] res, output int lat);
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!out_Done && lat < 40);
      res = out_MulResult;
      if (!out_Done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout, no Done within %0d edges", name, lat);
      end
   endtask

   task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic ac, input logic [63:0] acc,
                            input logic [63:0] exp);
      logic [63:0] res;
      int          lat;
      @(negedge clock);
      start_op(a, b, s, ac, acc);
      wait_done(name, res, lat);
      chk64(name, res, exp);
      chk_int({name, "_lat"}, lat, exp_lat(b, s));
   endtask

   // Busy and Done must never be high together
   always @(negedge clock) begin
      if (out_Busy && out_Done) begin
         n_checks++;
         n_fail++;
         $display("FAIL busy_done_overlap: busy=%0d done=%0d required not both 1", out_Busy, out_Done);
      end
   end

   initial begin
      vec_t        tbl[10];
      logic [63:0] res, r2, held;
      int          lat, seen;
      logic [31:0] ra, rb;
      logic        rs, rac;
      logic [63:0] racc;

      tbl[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 64'hFFFFFFFE_00000001};
      tbl[1] = '{32'hFFFFFFFF, 32'h00000005, 1'b1, 1'b0, 64'h0, 64'hFFFFFFFF_FFFFFFFB};
      tbl[2] = '{32'hFFFFFFFF, 32'h00000005, 1'b0, 1'b0, 64'h0, 64'h00000004_FFFFFFFB};
      tbl[3] = '{32'h00000003, 32'h00000004, 1'b0, 1'b1, 64'h00000000_FFFFFFFF, 64'h00000001_0000000B};
      tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h3FFFFFFF_FFFFFFFF};
      tbl[5] = '{32'h00000007, 32'h00000002, 1'b1, 1'b0, 64'h0, 64'h00000000_0000000E};
      tbl[6] = '{32'h00000007, 32'hFFFFFFFF, 1'b1, 1'b0, 64'h0, 64'hFFFFFFFF_FFFFFFF9};
      tbl[7] = '{32'h00000001, 32'h80000000, 1'b0, 1'b0, 64'h0, 64'h00000000_80000000};
      tbl[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0};
      tbl[9] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 64'h0, 64'hC0000000_80000000};

      reset = 1'b1; in_Start = 1'b0; in_a = '0; in_b = '0;
      in_Signed = 1'b0; in_Accumulate = 1'b0; in_AccValue = '0;
      repeat (3) @(posedge clock);
      #1;
      chk_int("reset_busy", int'(out_Busy), 0);
      chk_int("reset_done", int'(out_Done), 0);
      chk64("reset_result", out_MulResult, 64'h0);
      @(negedge clock); reset = 1'b0;

      for (int i = 0; i < 10; i++)
         run_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].ac, tbl[i].acc, tbl[i].exp);

      // result holds after Done until the next operation completes
      held = out_MulResult;
      repeat (4) @(posedge clock);
      #1;
      chk64("result_hold", out_MulResult, held);

      // Start during RUN is ignored
      @(negedge clock);
      start_op(32'd3, 32'd5, 1'b0, 1'b0, 64'h0);
      repeat (4) @(posedge clock);
      @(negedge clock);
      in_a = 32'd1000; in_b = 32'h7FFF0000; in_Start = 1'b1;
      @(negedge clock);
      in_Start = 1'b0;
      lat = 0;
      do begin @(posedge clock); #1; lat++; end while (!out_Done && lat < 40);
      chk64("start_in_run_ignored", out_MulResult, 64'd15);
      chk_int("start_in_run_lat", lat + 5, exp_lat(32'd5, 1'b0));

      // back-to-back: start accepted in the Done cycle
      run_check("b2b_first", 32'd6, 32'd9, 1'b0, 1'b0, 64'h0, 64'd54);
      chk_int("b2b_done_cycle", int'(out_Done), 1);
      start_op(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 64'h0);
      wait_done("b2b_second", r2, lat);
      chk64("b2b_second", r2, 64'hFFFFFFFF_FFFFFFFA);
      chk_int("b2b_second_lat", lat + 1, exp_lat(32'd3, 1'b1) + 1);

      // reset mid-run aborts with no Done
      @(negedge clock);
      start_op(32'h12345678, 32'h40000001, 1'b0, 1'b0, 64'h0);
      repeat (7) @(posedge clock);
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      chk_int("abort_busy", int'(out_Busy), 0);
      chk_int("abort_done", int'(out_Done), 0);
      chk64("abort_result", out_MulResult, 64'h0);
      @(negedge clock); reset = 1'b0;
      seen = 0;
      repeat (25) begin @(posedge clock); #1; if (out_Done) seen++; end
      chk_int("abort_no_done", seen, 0);

      // randomized operations against the arithmetic model
      for (int i = 0; i < 30; i++) begin
         ra   = $urandom;
         rb   = (i % 5 == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
         if (i % 7 == 3) rb = ~rb | 32'hFFFFFF00;
         rs   = 1'($urandom_range(0, 1));
         rac  = 1'($urandom_range(0, 1));
         racc = {$urandom, $urandom};
         run_check($sformatf("rand%0d", i), ra, rb, rs, rac, racc, model(ra, rb, rs, rac, racc));
      end

      res = 64'h0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + int'(res[0]));
      $finish;
   end

endmodule
